// File: rtl/x_uart_cmd_pkg.sv
// Shared types and field positions for the UART command decoder.
// A command byte carries a 2-bit opcode in the top bits and a 6-bit register address below it.
package x_uart_cmd_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } opcode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_t;

    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 6;
    localparam int ADDR_MSB = 5;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

    function automatic opcode_t byte_op(input logic [7:0] b);
        return opcode_t'(b[OP_MSB:OP_LSB]);
    endfunction

    function automatic logic [ADDR_W-1:0] byte_addr(input logic [7:0] b);
        return b[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/x_uart_cmd_regfile.sv
// Bank of 8-bit configuration registers with one-hot write strobes and a read mux.
// Addresses at or beyond p_regs match no register, so such writes are ignored and such reads return 0x00.
module x_uart_cmd_regfile
    import x_uart_cmd_pkg::*;
#(
    parameter int p_regs = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [p_regs*8-1:0]   regs,
    output logic [p_regs-1:0]     wr_strobe,
    output logic [7:0]            rd_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            regs      <= '0;
            wr_strobe <= '0;
        end else begin
            for (int k = 0; k < p_regs; k++) begin
                wr_strobe[k] <= wr_en && (wr_addr == ADDR_W'(k));
                if (wr_en && (wr_addr == ADDR_W'(k))) begin
                    regs[k*8 +: 8] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < p_regs; k++) begin
            if (rd_addr == ADDR_W'(k)) begin
                rd_data = regs[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/x_uart_cmd.sv
// Command decoder behind the UART receiver: two-byte writes and one-byte reads into a small register bank.
// Read responses go out through a one-entry buffer on a valid/ready byte port.
module x_uart_cmd
    import x_uart_cmd_pkg::*;
#(
    parameter int p_regs    = 8,
    parameter int p_timeout = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    output logic                  o_tx_valid,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_ready,
    output logic [p_regs*8-1:0]   o_regs,
    output logic [p_regs-1:0]     o_wr_strobe,
    output logic                  o_err
);

    localparam int TW = (p_timeout > 1) ? $clog2(p_timeout) : 1;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [ADDR_W-1:0]   waddr;
    logic                wr_en;
    logic                slot_free;
    logic [7:0]          rd_data;
    opcode_t             op;
    logic [ADDR_W-1:0]   cmd_addr;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < p_regs;
    endfunction

    assign op        = byte_op(i_data);
    assign cmd_addr  = byte_addr(i_data);
    assign wr_en     = (state == WDATA) && i_valid && in_range(waddr);
    // A READ may load the buffer if it is empty or being drained this very cycle.
    assign slot_free = !o_tx_valid || i_tx_ready;

    x_uart_cmd_regfile #(
        .p_regs (p_regs)
    ) u_regfile (
        .clk       (i_clk),
        .rst       (i_rst),
        .wr_en     (wr_en),
        .wr_addr   (waddr),
        .wr_data   (i_data),
        .rd_addr   (cmd_addr),
        .regs      (o_regs),
        .wr_strobe (o_wr_strobe),
        .rd_data   (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            timer      <= '0;
            waddr      <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            o_err      <= 1'b0;
        end else begin
            if (o_tx_valid && i_tx_ready) begin
                o_tx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (i_valid) begin
                        case (op)
                            OP_NOP:   o_err <= 1'b0;
                            OP_WRITE: begin
                                state <= WDATA;
                                waddr <= cmd_addr;
                            end
                            OP_READ: begin
                                if (slot_free) begin
                                    o_tx_valid <= 1'b1;
                                    o_tx_data  <= rd_data;
                                    if (!in_range(cmd_addr)) o_err <= 1'b1;
                                end else begin
                                    o_err <= 1'b1;
                                end
                            end
                            default:  o_err <= 1'b1;
                        endcase
                    end
                end
                WDATA: begin
                    // A data byte arriving on the timeout cycle still wins.
                    if (i_valid) begin
                        state <= IDLE;
                        timer <= '0;
                        if (!in_range(waddr)) o_err <= 1'b1;
                    end else if (timer == TW'(p_timeout - 1)) begin
                        state <= IDLE;
                        timer <= '0;
                        o_err <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x_uart_cmd.sv
// Bench for x_uart_cmd: vector table, directed corner sequences, then random bytes against a reference model.
module tb_x_uart_cmd;

    localparam int REGS = 8;
    localparam int TO   = 1024;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid;
    logic [7:0]           data;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic [REGS*8-1:0]    regs;
    logic [REGS-1:0]      strobe;
    logic                 err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    x_uart_cmd #(
        .p_regs    (REGS),
        .p_timeout (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_data      (data),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .o_regs      (regs),
        .o_wr_strobe (strobe),
        .o_err       (err)
    );

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         rdy;
        logic [7:0] s;
        bit         txv;
        logic [7:0] txd;
        bit         e;
    } vec_t;

    vec_t tbl [20];

    // Reference model: register array, pending-write flag and response buffer.
    logic [7:0]      m_regs [64];
    logic [REGS-1:0] m_strobe;
    bit              m_txv;
    logic [7:0]      m_txd;
    bit              m_err;
    bit              m_pend;
    int              m_paddr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        valid = 1'b1;
        data  = b;
        tick();
        valid = 1'b0;
    endtask

    function automatic vec_t mk(bit v, logic [7:0] d, bit rdy, logic [7:0] s, bit txv, logic [7:0] txd, bit e);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.s = s; r.txv = txv; r.txd = txd; r.e = e;
        return r;
    endfunction

    function automatic logic [REGS*8-1:0] m_flat();
        logic [REGS*8-1:0] f;
        for (int k = 0; k < REGS; k++) f[k*8 +: 8] = m_regs[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 64; k++) m_regs[k] = 8'h00;
        m_strobe = '0;
        m_txv    = 1'b0;
        m_txd    = 8'h00;
        m_err    = 1'b0;
        m_pend   = 1'b0;
        m_paddr  = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit rdy);
        int a;
        a = int'(d[5:0]);
        m_strobe = '0;
        if (m_txv && rdy) m_txv = 1'b0;
        if (v) begin
            if (m_pend) begin
                m_pend = 1'b0;
                if (m_paddr < REGS) begin
                    m_regs[m_paddr]   = d;
                    m_strobe[m_paddr] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                case (d[7:6])
                    2'd0: m_err = 1'b0;
                    2'd1: begin
                        m_pend  = 1'b1;
                        m_paddr = a;
                    end
                    2'd2: begin
                        if (!m_txv) begin
                            m_txv = 1'b1;
                            m_txd = (a < REGS) ? m_regs[a] : 8'h00;
                            if (a >= REGS) m_err = 1'b1;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    default: m_err = 1'b1;
                endcase
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        valid    = 1'b0;
        data     = 8'h00;
        tx_ready = 1'b0;

        tbl[0]  = mk(1, 8'h43, 0, 8'h00, 0, 8'h00, 0);
        tbl[1]  = mk(1, 8'hA5, 0, 8'h08, 0, 8'h00, 0);
        tbl[2]  = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        tbl[3]  = mk(1, 8'h83, 0, 8'h00, 1, 8'hA5, 0);
        tbl[4]  = mk(0, 8'h00, 0, 8'h00, 1, 8'hA5, 0);
        tbl[5]  = mk(1, 8'hC0, 0, 8'h00, 1, 8'hA5, 1);
        tbl[6]  = mk(1, 8'h00, 0, 8'h00, 1, 8'hA5, 0);
        tbl[7]  = mk(1, 8'h80, 0, 8'h00, 1, 8'hA5, 1);
        tbl[8]  = mk(1, 8'h00, 0, 8'h00, 1, 8'hA5, 0);
        tbl[9]  = mk(1, 8'h80, 1, 8'h00, 1, 8'h00, 0);
        tbl[10] = mk(0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
        tbl[11] = mk(1, 8'h7F, 0, 8'h00, 0, 8'h00, 0);
        tbl[12] = mk(1, 8'h11, 0, 8'h00, 0, 8'h00, 1);
        tbl[13] = mk(1, 8'hBF, 0, 8'h00, 1, 8'h00, 1);
        tbl[14] = mk(0, 8'h00, 1, 8'h00, 0, 8'h00, 1);
        tbl[15] = mk(1, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        tbl[16] = mk(1, 8'h42, 0, 8'h00, 0, 8'h00, 0);
        tbl[17] = mk(1, 8'h5A, 0, 8'h04, 0, 8'h00, 0);
        tbl[18] = mk(1, 8'h82, 0, 8'h00, 1, 8'h5A, 0);
        tbl[19] = mk(0, 8'h00, 1, 8'h00, 0, 8'h5A, 0);

        tick();
        tick();
        check("rst_regs",   regs,     '0);
        check("rst_strobe", strobe,   '0);
        check("rst_txv",    tx_valid, 1'b0);
        check("rst_txd",    tx_data,  8'h00);
        check("rst_err",    err,      1'b0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            valid    = tbl[i].v;
            data     = tbl[i].d;
            tx_ready = tbl[i].rdy;
            tick();
            valid = 1'b0;
            check($sformatf("tbl%0d_strobe", i), strobe,   tbl[i].s);
            check($sformatf("tbl%0d_txv", i),    tx_valid, tbl[i].txv);
            check($sformatf("tbl%0d_txd", i),    tx_data,  tbl[i].txd);
            check($sformatf("tbl%0d_err", i),    err,      tbl[i].e);
        end
        check("tbl_regs", regs, 64'h00000000_A55A0000);

        // Response held while the consumer stalls, dropped one cycle after the handshake.
        tx_ready = 1'b0;
        send(8'h83);
        for (int i = 0; i < 20; i++) begin
            check("hold", {tx_valid, tx_data}, {1'b1, 8'hA5});
            tick();
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("hold_release", tx_valid, 1'b0);

        // Abandoned write times out exactly p_timeout+1 cycles after the command.
        send(8'h41);
        repeat (TO - 1) tick();
        check("pre_timeout_err", err, 1'b0);
        tick();
        check("timeout_err",  err,         1'b1);
        check("timeout_reg1", regs[15:8],  8'h00);
        send(8'h00);
        check("nop_clears", err, 1'b0);

        // Data byte on the final timer cycle is still accepted.
        send(8'h41);
        repeat (TO - 1) tick();
        send(8'h77);
        check("edge_strobe", strobe,     8'h02);
        check("edge_err",    err,        1'b0);
        check("edge_reg1",   regs[15:8], 8'h77);

        // Reset in the middle of a write discards it; next byte is a command again.
        send(8'h42);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_regs", regs, '0);
        send(8'h55);
        send(8'h33);
        check("post_rst_strobe", strobe, '0);
        check("post_rst_err",    err,    1'b1);
        check("post_rst_regs",   regs,   '0);

        // Random traffic against the reference model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 800; c++) begin
            bit         v;
            bit         rdy;
            logic [7:0] d;
            v      = ($urandom_range(0, 2) == 0);
            rdy    = ($urandom_range(0, 1) == 1);
            d[7:6] = 2'($urandom_range(0, 3));
            d[5:0] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
            valid    = v;
            data     = d;
            tx_ready = rdy;
            model_step(v, d, rdy);
            tick();
            check("rand", {regs, strobe, tx_valid, tx_data, err},
                          {m_flat(), m_strobe, m_txv, m_txd, m_err});
        end
        valid    = 1'b0;
        tx_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/x_uart_cmd.md
# x_uart_cmd

Byte-level command decoder placed directly downstream of the UART receiver. Consumes each received byte (single-cycle valid strobe plus data), decodes a two-byte write / one-byte read protocol, and maintains a small bank of 8-bit configuration registers that drive the delay-line control logic. Read responses are presented on a valid/ready byte port intended for the UART transmitter.

## Interface
- p_regs, 8, number of 8-bit registers (1..64); address width p_aw = max(1, $clog2(p_regs))
- p_timeout, 1024, idle cycles allowed between a WRITE command byte and its data byte
- i_clk  input  1  clock
- i_rst  input  1  reset; synchronous, active-high
- i_valid  input  1  one-cycle strobe: i_data holds a received byte
- i_data  input  8  received byte
- o_tx_valid  output  1  read response byte available
- o_tx_data  output  8  read response byte
- i_tx_ready  input  1  consumer accepts o_tx_data when o_tx_valid & i_tx_ready
- o_regs  output  p_regs*8  register bank, register k at [8k+7:8k]
- o_wr_strobe  output  p_regs  one-cycle pulse on bit k when register k is written
- o_err  output  1  sticky error flag

## Operation
- Command byte: opcode = [7:6], addr = [5:0].
  - 00 NOP: clears o_err.
  - 01 WRITE: next byte is the data for register addr.
  - 10 READ: returns register addr on the tx port.
  - 11 reserved: ignored, sets o_err.
- Parser FSM:
  - IDLE: on i_valid decode the byte. WRITE -> WDATA, latch addr, clear timer. All other opcodes stay in IDLE.
  - WDATA: on i_valid write the latched addr with i_data -> IDLE. On timer == p_timeout-1 without i_valid -> IDLE and set o_err.
- Timer increments every cycle in WDATA and holds 0 elsewhere. i_valid in the same cycle as timeout: the byte is taken as data and no error is raised.
- Address out of range (addr >= p_regs):
  - WRITE: still consumes its data byte, no register changes, no strobe, sets o_err.
  - READ: returns 0x00 and sets o_err.
- Response buffer is one entry deep. A READ loads it and raises o_tx_valid; o_tx_valid and o_tx_data hold until a handshake.
- READ arriving while the buffer is full:
  - Accepted in the same cycle (o_tx_valid & i_tx_ready): the new response loads and o_tx_valid stays high.
  - Otherwise the READ is dropped and o_err is set.
- o_err is set by any error above, cleared only by NOP or reset. Set and clear in the same cycle is impossible, since each byte carries one opcode.
- Reset values: o_regs all 0, o_wr_strobe 0, o_tx_valid 0, o_tx_data 0x00, o_err 0, FSM IDLE, timer 0. Reset mid-WDATA discards the pending write.

## Timing
- WRITE: data byte strobed in cycle N -> o_regs updated and o_wr_strobe[k] high in cycle N+1, strobe low in N+2.
- READ: command strobed in cycle N -> o_tx_valid high with data in cycle N+1. The data is a snapshot of the register at cycle N, so a write landing at N+1 is not reflected.
- Handshake in cycle M with no new READ -> o_tx_valid low in M+1.
- Timeout: WRITE strobed in cycle N with no further i_valid -> FSM back in IDLE and o_err high in cycle N+p_timeout+1.
- No combinational path from i_valid/i_data to any output. o_tx_valid does not depend combinationally on i_tx_ready.
- Upstream strobes are at least one UART frame apart. Back-to-back i_valid on consecutive cycles must still be handled correctly.

## Structure
- Package x_uart_cmd_pkg:
  - opcode enum (OP_NOP, OP_WRITE, OP_READ, OP_RSVD)
  - parser state enum (IDLE, WDATA)
  - field localparams for opcode and addr bit positions
- Sub-module x_uart_cmd_regfile:
  - inputs: write enable, address, data
  - outputs: flattened o_regs, one-hot o_wr_strobe, and the read mux
  - the parser, timer, response buffer and error logic stay in x_uart_cmd

## Test plan
- Reset, then 0x43, 0xA5 -> o_regs[31:24]=0xA5 and o_wr_strobe=8'b0000_1000 for one cycle, cycle after 0xA5.
- After the write above, send 0x83 with i_tx_ready=0 -> o_tx_valid=1, o_tx_data=0xA5, held 20 cycles; raise i_tx_ready -> o_tx_valid=0 next cycle.
- Send 0x41, then wait p_timeout+2 cycles with no bytes -> o_err=1, register 1 unchanged; then send 0x00 -> o_err=0.
- Send 0x7F, 0x11 (addr 63 with p_regs=8) -> no register change, no strobe, o_err=1; then 0xBF -> o_tx_data=0x00.
- With o_tx_valid held and i_tx_ready=0, send 0x80 -> response unchanged and o_err=1. Repeat with i_tx_ready=1 in the strobe cycle -> new response loaded and o_err stays 0.
- Assert i_rst one cycle after 0x42 -> o_regs all 0 and FSM in IDLE; a following 0x55 is decoded as a WRITE command to addr 0x15.
